// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter owner and instruction-fetch stage.
// Drives the async program ROM from PC and registers one word per cycle
// into a valid/ready slot toward decode. Unconditional jumps redirect PC
// with no penalty; conditional jumps park in WAIT_BR and feed NOP bubbles
// until execute resolves the branch.
module fetch_sequencer #(
  parameter logic [9:0] NOP_WORD = 10'b0000_000000,
  parameter logic [3:0] JMP_OP   = 4'b1011,
  parameter logic [3:0] JC_OP    = 4'b1100
) (
  input  logic       CLK,
  input  logic       N_RST,
  output logic [5:0] ROM_AD,
  input  logic [9:0] ROM_Q,
  output logic [9:0] INSN,
  output logic [5:0] INSN_PC,
  output logic       INSN_VALID,
  input  logic       INSN_READY,
  input  logic       BR_RESOLVE,
  input  logic       BR_TAKEN,
  input  logic [5:0] BR_TARGET,
  output logic [7:0] BUB_CNT
);

  typedef enum logic {S_RUN, S_WAIT_BR} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_pc;
  logic [5:0] w_pc_nxt;
  logic [9:0] r_insn;
  logic [5:0] r_insn_pc;
  logic       r_insn_valid;
  logic [7:0] r_bub_cnt;

  logic       w_slot_free;
  logic       w_fetch;
  logic       w_bubble;
  logic [3:0] w_opcode;
  logic [5:0] w_operand;

  assign w_slot_free = !r_insn_valid || INSN_READY;
  assign w_opcode    = ROM_Q[9:6];
  assign w_operand   = ROM_Q[5:0];

  // Next-state / next-PC and slot-load decision. Every slot-free cycle
  // loads something: a ROM word in RUN, a bubble in WAIT_BR.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fetch     = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_slot_free) begin
          w_fetch = 1'b1;
          if (w_opcode == JMP_OP) begin
            w_pc_nxt = w_operand;
          end else if (w_opcode == JC_OP) begin
            w_pc_nxt    = r_pc + 6'd1;
            w_state_nxt = S_WAIT_BR;
          end else begin
            w_pc_nxt = r_pc + 6'd1;
          end
        end
      end
      S_WAIT_BR: begin
        // Resolution applies regardless of back-pressure; PC already
        // holds the fall-through address, so only a taken branch moves it.
        if (BR_RESOLVE) begin
          w_state_nxt = S_RUN;
          if (BR_TAKEN) w_pc_nxt = BR_TARGET;
        end
        // ROM is never sampled here, even in the resolve cycle, so the
        // redirected PC is fetched one edge later.
        if (w_slot_free) w_bubble = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State and program counter.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_state <= S_RUN;
      r_pc    <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Decode-facing slot; holds completely while decode stalls it.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_insn       <= NOP_WORD;
      r_insn_pc    <= 6'd0;
      r_insn_valid <= 1'b0;
    end else if (w_fetch) begin
      r_insn       <= ROM_Q;
      r_insn_pc    <= r_pc;
      r_insn_valid <= 1'b1;
    end else if (w_bubble) begin
      // Bubbles keep the PC of the last real word issued.
      r_insn       <= NOP_WORD;
      r_insn_valid <= 1'b1;
    end else if (w_slot_free) begin
      r_insn_valid <= 1'b0;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_bub_cnt <= 8'd0;
    end else if (w_bubble && (r_bub_cnt != 8'hFF)) begin
      r_bub_cnt <= r_bub_cnt + 8'd1;
    end
  end

  assign ROM_AD     = r_pc;
  assign INSN       = r_insn;
  assign INSN_PC    = r_insn_pc;
  assign INSN_VALID = r_insn_valid;
  assign BUB_CNT    = r_bub_cnt;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 6-bit CPU. It owns the program counter and drives the asynchronous 64-word × 10-bit program ROM. It presents one instruction per cycle to decode through a valid/ready register stage. Unconditional jumps are resolved locally. For conditional jumps it interlocks against execute and inserts NOP bubbles in hardware, so programs no longer need hand-placed NOP padding after branches.

## Interface
- `NOP_WORD`, default 10'b0000_000000: word issued as a bubble.
- `JMP_OP`, default 4'b1011: unconditional jump opcode; operand is the target.
- `JC_OP`, default 4'b1100: conditional jump opcode; resolved by execute.
- `CLK` input 1: single clock; all state on rising edge.
- `N_RST` input 1: reset, asynchronous and active-low.
- `ROM_AD` output 6: ROM address, combinationally equal to PC.
- `ROM_Q` input 10: ROM data, {opcode[9:6], operand[5:0]}, valid the same cycle.
- `INSN` output 10: instruction to decode.
- `INSN_PC` output 6: address `INSN` was fetched from (bubbles carry last PC).
- `INSN_VALID` output 1: `INSN` holds an unconsumed word.
- `INSN_READY` input 1: decode accepts `INSN` this cycle.
- `BR_RESOLVE` input 1: execute reports outcome of the pending `JC_OP` (1-cycle pulse).
- `BR_TAKEN` input 1: qualifies `BR_RESOLVE`; 1 = taken.
- `BR_TARGET` input 6: taken target, qualified by `BR_RESOLVE`.
- `BUB_CNT` output 8: count of inserted bubbles, saturating at 255.

## Operation
- Slot free = `!INSN_VALID || INSN_READY`. Nothing loads into `INSN` unless the slot is free. When the slot is not free, all of `INSN`/`INSN_PC`/`INSN_VALID` hold.
- States: RUN, WAIT_BR.
- RUN, slot free:
  - `INSN<=ROM_Q`, `INSN_PC<=PC`, `INSN_VALID<=1`.
  - If opcode == `JMP_OP`: `PC<=operand`; stay RUN.
  - If opcode == `JC_OP`: `PC<=PC+1`; go to WAIT_BR.
  - Otherwise: `PC<=PC+1`.
  - PC is 6-bit and wraps 63→0.
- RUN, slot not free: PC and state hold.
- WAIT_BR, no `BR_RESOLVE`, slot free: `INSN<=NOP_WORD`, `INSN_VALID<=1`, `BUB_CNT++` (saturating). PC holds.
- WAIT_BR, `BR_RESOLVE`=1:
  - If `BR_TAKEN`, `PC<=BR_TARGET`; else PC keeps the fall-through value.
  - State goes to RUN.
  - If the slot is free, one more bubble is issued (counted). The ROM is not sampled this cycle.
- `BR_RESOLVE` in RUN is ignored: no PC or state change.
- `BR_RESOLVE` with slot not free: resolution still applies, and no bubble is issued.
- If slot not free in either state, `INSN_VALID` stays 1; decode back-pressure never drops or duplicates a word.
- `JMP_OP` to its own address (halt idiom) repeats indefinitely; no special handling.

## Timing
- Reset (`N_RST`=0, asynchronous): PC=0, state=RUN, `INSN`=`NOP_WORD`, `INSN_PC`=0, `INSN_VALID`=0, `BUB_CNT`=0, so `ROM_AD`=0.
- First edge after reset release with slot free: `INSN`=ROM[0], `INSN_VALID`=1.
- Fetch latency: 1 edge from PC to `INSN`. Throughput is 1 instruction/cycle when `INSN_READY`=1.
- `JMP_OP` taken penalty: 0 bubbles. The target is fetched on the next edge.
- `JC_OP` penalty: one bubble per slot-free cycle in WAIT_BR, plus one in the resolve cycle. If `BR_RESOLVE` is sampled at edge k, `INSN` = ROM[target or fall-through] after edge k+1.
- Outputs are registered except `ROM_AD`.

## Test plan
- **Reset/streaming:** ROM[0..3] = non-branch words, `INSN_READY`=1. Release reset. Required: `INSN`/`INSN_PC` = ROM[0]/0, ROM[1]/1, ROM[2]/2 on consecutive edges; `BUB_CNT`=0.
- **Back-pressure:** hold `INSN_READY`=0 for 3 cycles after ROM[1] is presented. Required: ROM[1] and `INSN_PC`=1 held stable. ROM[2] follows on the first edge after `INSN_READY` returns to 1. No word is skipped.
- **Jump / halt:** ROM[9] = {1011, 9}. Required: `INSN_PC` = 9 on every edge thereafter; `BUB_CNT` unchanged.
- **Conditional taken:** ROM[4] = {1100, 1}. Assert `BR_RESOLVE`=1, `BR_TAKEN`=1, `BR_TARGET`=1 on the 3rd cycle after ROM[4] is issued. Required: three `NOP_WORD` bubbles, then ROM[1] with `INSN_PC`=1; `BUB_CNT`=3.
- **Conditional not taken:** same setup with `BR_TAKEN`=0. Required: bubbles, then ROM[5] with `INSN_PC`=5.
- **Edge cases:**
  - Wrap: ROM[63] non-branch is followed by ROM[0].
  - Spurious `BR_RESOLVE` in RUN has no effect.
  - Asserting `N_RST`=0 mid-WAIT_BR immediately gives PC=0, `INSN_VALID`=0, state RUN.
  - Saturation: force 300 bubbles; required `BUB_CNT`=255.
